shared_mem_arbiter: RTL
=======================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 SHALL have parameter PROCS, default 4, number of requesting cores (2..16).
REQ-002 SHALL have parameter ADDR_W, default 14, memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, write/read data width.
REQ-004 SHALL have parameter ARB_MODE, default ARB_RR, arbitration mode (ARB_RR round-robin, ARB_FIXED lowest-index-wins).
REQ-005 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before abort (>=1).
REQ-006 SHALL run on one clock with synchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req, input, PROCS, per-core level request.
REQ-009 SHALL have port we, input, PROCS, per-core write (1) / read (0) select.
REQ-010 SHALL have port addr, input, PROCS x ADDR_W, per-core address.
REQ-011 SHALL have port wdata, input, PROCS x DATA_W, per-core write data.
REQ-012 SHALL have port grant, output, PROCS, one-hot one-cycle pulse: request accepted.
REQ-013 SHALL have port resp, output, PROCS, one-hot one-cycle pulse: transaction complete.
REQ-014 SHALL have port err, output, PROCS, pulses with resp on timeout.
REQ-015 SHALL have port rdata, output, DATA_W, read data, valid only in the resp cycle.
REQ-016 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_re (output, 1), mem_we (output, 1): shared memory command.
REQ-017 SHALL have ports mem_resp (input, 1) and mem_rdata (input, DATA_W): memory completion and read data.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; all outputs registered.
REQ-019 In IDLE with any req high at edge n, SHALL select one winner, latch its we/addr/wdata, enter ISSUE at n+1.
REQ-020 In ISSUE, SHALL assert grant[winner] plus mem_re (read) or mem_we (write) for exactly one cycle, then enter WAIT.
REQ-021 mem_resp in the ISSUE cycle SHALL be ignored; memory response accepted from first WAIT cycle on.
REQ-022 In WAIT, mem_resp high SHALL cause next cycle: resp[winner]=1, rdata=mem_rdata (read) or 0 (write), state IDLE.
REQ-023 Minimum req-to-resp latency SHALL be 3 cycles (mem_resp in first WAIT cycle).
REQ-024 WAIT counter SHALL count from 0; on reaching TIMEOUT without mem_resp, next cycle SHALL pulse resp[winner] and err[winner], rdata=0, return to IDLE.
REQ-025 ARB_RR: search SHALL start at pointer ptr, wrap PROCS-1 -> 0; on each grant ptr <= (winner+1) mod PROCS.
REQ-026 ARB_FIXED: lowest-index active req SHALL win; ptr unused.
REQ-027 req high in the IDLE cycle following resp SHALL be treated as a new request (back-to-back allowed, no idle gap required).
REQ-028 req/we/addr/wdata SHALL be sampled only in IDLE; changes during ISSUE/WAIT SHALL not affect the current transaction.
REQ-029 Request dropped before arbitration SHALL be lost silently; no grant.
REQ-030 Exactly one mem_re/mem_we pulse SHALL be issued per grant; mem_addr/mem_wdata SHALL hold latched values from ISSUE through WAIT.

Reset
REQ-031 Reset SHALL force state IDLE, ptr=0, WAIT counter 0, grant/resp/err=0, mem_re=mem_we=0, mem_addr/mem_wdata/rdata=0.
REQ-032 Reset mid-ISSUE/WAIT SHALL abandon the transaction with no resp or err pulse; late mem_resp after reset SHALL be ignored in IDLE.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the FSM state enum and ARB_RR/ARB_FIXED mode constants.
REQ-035 Combinational winner selection SHALL be a sub-module rr_priority_picker (inputs req, ptr, mode; output one-hot winner, index).

Verification
REQ-036 Single read: core 2 req, addr=0x0123, mem_resp 2 cycles after mem_re, mem_rdata=0xBEEF -> grant[2] once, mem_addr=0x0123, resp[2] with rdata=0xBEEF.
REQ-037 RR fairness: all 4 req held high, immediate mem_resp -> grant order 0,1,2,3,0; no core granted twice before others.
REQ-038 ARB_FIXED: req 0 and 3 held high -> core 0 granted repeatedly, core 3 never until req[0] drops.
REQ-039 Timeout: TIMEOUT=8, core 1 write, no mem_resp -> resp[1] and err[1] pulse 9 cycles after first WAIT cycle; next request served normally.
REQ-040 Reset in WAIT: core 0 read pending, assert reset 1 cycle -> no resp/err, all outputs 0, ptr=0; mem_resp arriving after reset ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared memory arbiter FSM states and arbitration mode constants
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic ARB_RR    = 1'b0;
   localparam logic ARB_FIXED = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational one-hot winner select, rotating or fixed priority
module rr_priority_picker
   import mem_arb_pkg::*;
#(
   parameter int PROCS = 4,
   parameter int IDX_W = 2
) (
   input  logic [PROCS-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             mode,
   output logic [PROCS-1:0] winner,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   int base;
   int slot;

   // Fixed mode is the rotating search with the start point pinned at core 0.
   always_comb begin
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      slot   = 0;
      base   = (mode == ARB_FIXED) ? 0 : int'(ptr);
      for (int i = 0; i < PROCS; i++) begin
         slot = (base + i) % PROCS;
         if (!valid && req[slot]) begin
            valid        = 1'b1;
            winner[slot] = 1'b1;
            index        = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - multi-core arbiter in front of a single-port shared memory
module shared_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int   PROCS    = 4,
   parameter int   ADDR_W   = 14,
   parameter int   DATA_W   = 16,
   parameter logic ARB_MODE = ARB_RR,
   parameter int   TIMEOUT  = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PROCS-1:0]         req,
   input  logic [PROCS-1:0]         we,
   input  logic [PROCS*ADDR_W-1:0]  addr,
   input  logic [PROCS*DATA_W-1:0]  wdata,
   output logic [PROCS-1:0]         grant,
   output logic [PROCS-1:0]         resp,
   output logic [PROCS-1:0]         err,
   output logic [DATA_W-1:0]        rdata,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_re,
   output logic                     mem_we,
   input  logic                     mem_resp,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int IDX_W = (PROCS > 1) ? $clog2(PROCS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state, state_d;
   logic [IDX_W-1:0]   ptr, ptr_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [PROCS-1:0]   win_oh, win_oh_d;
   logic               lat_we, lat_we_d;
   logic [PROCS-1:0]   grant_d, resp_d, err_d;
   logic [DATA_W-1:0]  rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic               mem_re_d, mem_we_d;

   logic [PROCS-1:0]   pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   rr_priority_picker #(
      .PROCS (PROCS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .mode   (ARB_MODE),
      .winner (pick_oh),
      .index  (pick_idx),
      .valid  (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         win_oh    <= '0;
         lat_we    <= 1'b0;
         grant     <= '0;
         resp      <= '0;
         err       <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         cnt       <= cnt_d;
         win_oh    <= win_oh_d;
         lat_we    <= lat_we_d;
         grant     <= grant_d;
         resp      <= resp_d;
         err       <= err_d;
         rdata     <= rdata_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_re    <= mem_re_d;
         mem_we    <= mem_we_d;
      end
   end

   // Outputs are computed one state early so that they are registered in the state they belong to.
   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      cnt_d       = cnt;
      win_oh_d    = win_oh;
      lat_we_d    = lat_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      grant_d     = '0;
      resp_d      = '0;
      err_d       = '0;
      rdata_d     = '0;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d     = ST_ISSUE;
               win_oh_d    = pick_oh;
               lat_we_d    = we[pick_idx];
               mem_addr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
               mem_wdata_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
               grant_d     = pick_oh;
               mem_re_d    = !we[pick_idx];
               mem_we_d    = we[pick_idx];
               if (ARB_MODE == ARB_RR)
                  ptr_d = (pick_idx == IDX_W'(PROCS - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            if (mem_resp) begin
               state_d = ST_IDLE;
               resp_d  = win_oh;
               rdata_d = lat_we ? '0 : mem_rdata;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               state_d = ST_IDLE;
               resp_d  = win_oh;
               err_d   = win_oh;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
